sw_debounce: RTL

- Input conditioning stage for the board's mechanical inputs: nav switches and user DIP switches.
- Sits between the top-level pads and the demo system's general-purpose input bus.
- Per channel: synchronises the raw pad level, removes pull-up inversion and filters contact bounce.
- Outputs a clean level vector for gp_i, plus one-cycle rise/fall pulses and a change strobe for interrupt logic.

---
 rtl/sw_debounce_pkg.sv | 17 +
 rtl/sw_debounce_chan.sv | 93 +++++++++
 rtl/sw_debounce.sv | 71 +++++++
 3 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the switch debouncer.
// Optional sticky event flags are enabled with SW_DEBOUNCE_STICKY_EN.
package sw_debounce_pkg;

    typedef enum logic [0:0] {
        DbStable,
        DbCounting
    } debounce_state_e;

    localparam int unsigned MinDebounceCycles = 2;

    // Clamp an out-of-range hold time to the shortest legal value.
    function automatic int unsigned legal_cycles(input int unsigned cycles);
        return (cycles < MinDebounceCycles) ? MinDebounceCycles : cycles;
    endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// One switch channel: two-flop synchroniser, polarity fix, bounce filter FSM
// and registered rise/fall pulses.
module sw_debounce_chan
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DebounceCycles = 250_000,
    parameter bit          ActiveLow      = 1'b1
) (
    input  logic clk_sys_i,
    input  logic rst_sys_i,
    input  logic sw_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o,
    output logic edge_d_o
);

    localparam int unsigned Cycles = legal_cycles(DebounceCycles);
    localparam int unsigned CntW   = $clog2(Cycles);
    localparam logic [CntW-1:0] CntMax = CntW'(Cycles - 1);
    localparam logic PadIdle = ActiveLow;

    logic            sync1_q, sync2_q;
    logic            s;
    debounce_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stable_q, stable_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    assign s = sync2_q ^ ActiveLow;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        unique case (state_q)
            DbStable: begin
                if (s != stable_q) begin
                    state_d = DbCounting;
                    cnt_d   = '0;
                end
            end
            DbCounting: begin
                if (s == stable_q) begin
                    state_d = DbStable;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    // Terminal compare comes first, so the counter never wraps.
                    stable_d = s;
                    rise_d   = s;
                    fall_d   = ~s;
                    state_d  = DbStable;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DbStable;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            sync1_q  <= PadIdle;
            sync2_q  <= PadIdle;
            state_q  <= DbStable;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign sw_o     = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign edge_d_o = rise_d | fall_d;

endmodule

// File: rtl/sw_debounce.sv
// Debounce/conditioning stage for nav and DIP switches feeding the GPIO bus.
// Defining SW_DEBOUNCE_STICKY_EN adds evt_clr_i/evt_o sticky event flags.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned Width          = 13,
    parameter int unsigned DebounceCycles = 250_000,
    parameter bit          ActiveLow      = 1'b1
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic [Width-1:0] sw_i,
    output logic [Width-1:0] sw_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
`ifdef SW_DEBOUNCE_STICKY_EN
    input  logic [Width-1:0] evt_clr_i,
    output logic [Width-1:0] evt_o,
`endif
    output logic             change_o
);

    logic [Width-1:0] edge_d;
    logic             change_q, change_d;

    for (genvar i = 0; i < Width; i++) begin : g_chan
        sw_debounce_chan #(
            .DebounceCycles(DebounceCycles),
            .ActiveLow     (ActiveLow)
        ) u_chan (
            .clk_sys_i(clk_sys_i),
            .rst_sys_i(rst_sys_i),
            .sw_i     (sw_i[i]),
            .sw_o     (sw_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i]),
            .edge_d_o (edge_d[i])
        );
    end

    // Registered from the channels' next-state pulses so it lines up with rise_o/fall_o.
    assign change_d = |edge_d;

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            change_q <= 1'b0;
        end else begin
            change_q <= change_d;
        end
    end

    assign change_o = change_q;

`ifdef SW_DEBOUNCE_STICKY_EN
    logic [Width-1:0] evt_q, evt_d;

    // Set wins over clear so an event landing with a clear is not lost.
    assign evt_d = (evt_q & ~evt_clr_i) | rise_o | fall_o;

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_o = evt_q;
`endif

endmodule
